// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory request channel and decode-side output channel of the fetch controller.
// The master modport is the fetch controller; the slave modport is memory plus decode.
interface ifetch_ctrl_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [DW-1:0] imem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_pc;
   logic [DW-1:0] out_instr;

   modport master (
      output imem_req, imem_addr, out_valid, out_pc, out_instr,
      input  imem_ack, imem_rdata, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_pc, out_instr,
      output imem_ack, imem_rdata, out_ready
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: steers the pc block, issues one memory request at a time
// and buffers {pc, instr} pairs in a 2-entry FIFO toward decode; redirects flush everything.
module ifetch_ctrl #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] pc_q,
   output logic          pc_ld,
   output logic          pc_inc,
   output logic [AW-1:0] pc_d,
   input  logic          redir_valid,
   input  logic [AW-1:0] redir_pc,
   ifetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] fifo_pc_q [2];
   logic [AW-1:0] fifo_pc_d [2];
   logic [DW-1:0] fifo_instr_q [2];
   logic [DW-1:0] fifo_instr_d [2];
   logic          rd_ptr_q, rd_ptr_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic [1:0]    count_q, count_d;
   logic          push, pop, flush, fifo_full;

   assign fifo_full     = (count_q == 2'(DEPTH));
   assign pop           = bus.out_valid && bus.out_ready;
   assign pc_d          = redir_pc;
   assign bus.imem_req  = (state_q != IDLE);
   assign bus.imem_addr = addr_q;
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_pc    = fifo_pc_q[rd_ptr_q];
   assign bus.out_instr = fifo_instr_q[rd_ptr_q];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pc_ld   = 1'b0;
      pc_inc  = 1'b0;
      push    = 1'b0;
      flush   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (redir_valid) begin
               pc_ld = 1'b1;
               flush = 1'b1;
            end else if (!fifo_full) begin
               addr_d  = pc_q;
               state_d = REQ;
            end
         end
         REQ: begin
            // A redirect racing the ack discards the word and must not advance the pc.
            if (redir_valid) begin
               pc_ld   = 1'b1;
               flush   = 1'b1;
               state_d = bus.imem_ack ? IDLE : DROP;
            end else if (bus.imem_ack) begin
               push    = 1'b1;
               pc_inc  = 1'b1;
               state_d = IDLE;
            end
         end
         DROP: begin
            if (redir_valid) begin
               pc_ld = 1'b1;
               flush = 1'b1;
            end
            if (bus.imem_ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_pc_d    = fifo_pc_q;
      fifo_instr_d = fifo_instr_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            fifo_pc_d[wr_ptr_q]    = addr_q;
            fifo_instr_d[wr_ptr_q] = bus.imem_rdata;
            wr_ptr_d               = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_pc_q[i]    <= '0;
            fifo_instr_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         fifo_pc_q    <= fifo_pc_d;
         fifo_instr_q <= fifo_instr_d;
      end
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl with a behavioural pc block and variable-latency memory;
// expected decode-side pairs are queued by the stimulus and checked by a separate monitor.
module tb_ifetch_ctrl;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] pc_q;
   logic          pc_ld;
   logic          pc_inc;
   logic [AW-1:0] pc_d;
   logic          redir_valid;
   logic [AW-1:0] redir_pc;

   int   compared   = 0;
   int   mismatched = 0;
   int   sb_pops    = 0;
   int   cnt_ld     = 0;
   int   cnt_inc    = 0;
   int   lat        = 1;
   exp_t exp_q [$];

   ifetch_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   ifetch_ctrl #(.AW(AW), .DW(DW), .DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_q        (pc_q),
      .pc_ld       (pc_ld),
      .pc_inc      (pc_inc),
      .pc_d        (pc_d),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .bus         (bus)
   );

   always #10 clk = ~clk;

   // Behavioural pc block: resets to 0x100, load wins over increment.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pc_q <= 32'h100;
      else if (pc_ld)  pc_q <= pc_d;
      else if (pc_inc) pc_q <= pc_q + 32'd4;
   end

   // Memory: acks after 'lat' cycles of a held request; word = {C0DE, addr[15:0]}.
   initial begin
      int wait_cnt;
      wait_cnt       = 0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && bus.imem_req) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};
            end else begin
               bus.imem_ack = 1'b0;
            end
         end else begin
            bus.imem_ack = 1'b0;
            wait_cnt     = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
      redir_valid   = rv;
      redir_pc      = rpc;
      bus.out_ready = rdy;
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      exp_q.push_back(e);
   endtask

   task automatic wait_req(input logic [31:0] addr, input int bound);
      int n = 0;
      while (!(bus.imem_req && bus.imem_addr == addr)) begin
         if (n >= bound) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_req timeout: no request for 0x%08h, imem_addr is 0x%08h", addr, bus.imem_addr);
            return;
         end
         step();
         n++;
      end
   endtask

   task automatic wait_pops(input int target, input int bound);
      int n = 0;
      while (sb_pops < target) begin
         if (n >= bound) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_pops timeout: got %0d accepted entries, expected %0d", sb_pops, target);
            return;
         end
         step();
         n++;
      end
   endtask

   // Monitor: compares every accepted FIFO head against the scoreboard queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (rst_n) begin
            if (pc_ld)  cnt_ld++;
            if (pc_inc) cnt_inc++;
            if (pc_ld) checkOutput("ld_inc_exclusive", {30'd0, pc_ld, pc_inc}, 32'd2);
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("[TB] FAIL unexpected_pop: got pc 0x%08h, expected no entry", bus.out_pc);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("out_pc", bus.out_pc, e.pc);
                  checkOutput("out_instr", bus.out_instr, e.instr);
                  sb_pops++;
               end
            end
         end
      end
   end

   initial begin
      int req_cycles;
      int held;
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1);
      lat = 1;
      repeat (3) step();

      checkOutput("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("rst_imem_addr", bus.imem_addr, 32'h0);
      checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("rst_pc_ld", {31'd0, pc_ld}, 32'd0);
      checkOutput("rst_pc_inc", {31'd0, pc_inc}, 32'd0);

      // Streaming fetch with single-cycle ack and decode always ready.
      expect_entry(32'h100, 32'hC0DE0100);
      expect_entry(32'h104, 32'hC0DE0104);
      expect_entry(32'h108, 32'hC0DE0108);
      expect_entry(32'h10C, 32'hC0DE010C);
      rst_n = 1'b1;
      wait_pops(4, 60);
      checkOutput("pc_inc_pulses", cnt_inc, 32'd4);
      checkOutput("pc_ld_pulses", cnt_ld, 32'd0);

      // Decode stalls: FIFO fills to two entries and fetching stops.
      expect_entry(32'h110, 32'hC0DE0110);
      expect_entry(32'h114, 32'hC0DE0114);
      expect_entry(32'h118, 32'hC0DE0118);
      applyStimulus(1'b0, 32'h0, 1'b0);
      repeat (3) step();
      req_cycles = 0;
      repeat (6) begin
         step();
         if (bus.imem_req) req_cycles++;
      end
      checkOutput("stall_req_cycles", req_cycles, 32'd0);
      checkOutput("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("stall_head_pc", bus.out_pc, 32'h110);
      checkOutput("stall_head_instr", bus.out_instr, 32'hC0DE0110);

      // Release decode; next fetch sees a 3-cycle memory latency.
      lat = 3;
      applyStimulus(1'b0, 32'h0, 1'b1);
      wait_req(32'h118, 10);
      held = 0;
      do begin
         held++;
         step();
      end while (bus.imem_req && bus.imem_addr == 32'h118 && held < 10);
      checkOutput("lat3_req_held", held, 32'd3);
      checkOutput("lat3_req_dropped", {31'd0, bus.imem_req}, 32'd0);
      lat = 4;

      // Redirect while a request waits: DROP until ack, then fetch from target.
      expect_entry(32'h200, 32'hC0DE0200);
      wait_req(32'h11C, 10);
      checkOutput("redir_wait_ack", {31'd0, bus.imem_ack}, 32'd0);
      applyStimulus(1'b1, 32'h200, 1'b1);
      #1;
      checkOutput("redir_pc_ld", {31'd0, pc_ld}, 32'd1);
      checkOutput("redir_pc_inc", {31'd0, pc_inc}, 32'd0);
      checkOutput("redir_pc_d", pc_d, 32'h200);
      step();
      applyStimulus(1'b0, 32'h0, 1'b1);
      #1;
      checkOutput("drop_pc_ld", {31'd0, pc_ld}, 32'd0);
      checkOutput("drop_imem_req", {31'd0, bus.imem_req}, 32'd1);
      checkOutput("drop_imem_addr", bus.imem_addr, 32'h11C);
      checkOutput("drop_out_valid", {31'd0, bus.out_valid}, 32'd0);
      lat = 1;

      // Redirect in the same cycle as the ack: word discarded, no increment.
      wait_req(32'h204, 20);
      checkOutput("race_ack", {31'd0, bus.imem_ack}, 32'd1);
      applyStimulus(1'b1, 32'h300, 1'b0);
      #1;
      checkOutput("race_pc_ld", {31'd0, pc_ld}, 32'd1);
      checkOutput("race_pc_inc", {31'd0, pc_inc}, 32'd0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0);
      wait_req(32'h300, 10);
      step();
      lat = 5;

      // Reset mid-request with one entry queued.
      wait_req(32'h304, 10);
      checkOutput("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("pre_rst_head_pc", bus.out_pc, 32'h300);
      checkOutput("pre_rst_head_instr", bus.out_instr, 32'hC0DE0300);
      #4;
      rst_n = 1'b0;
      #2;
      checkOutput("midrst_imem_req", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("midrst_imem_addr", bus.imem_addr, 32'h0);
      checkOutput("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("midrst_pc_ld", {31'd0, pc_ld}, 32'd0);
      checkOutput("midrst_pc_inc", {31'd0, pc_inc}, 32'd0);
      step();
      step();
      expect_entry(32'h100, 32'hC0DE0100);
      expect_entry(32'h104, 32'hC0DE0104);
      lat = 2;
      applyStimulus(1'b0, 32'h0, 1'b1);
      rst_n = 1'b1;
      wait_pops(10, 100);
      applyStimulus(1'b0, 32'h0, 1'b0);
      repeat (2) step();
      checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
